// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 opcode/funct constants, ALU op encoding and
// the per-lane decoded control bundle used by decode_lane and decode_stage.
package decode_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRA     = 3'b101;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // RV32 immediates always fit in 32 bits; the stage widens them to XLEN.
    localparam int IMM_W = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_XOR = 3'b010,
        ALU_SRA = 3'b011,
        ALU_AND = 3'b100
    } alu_op_t;

    typedef struct packed {
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [IMM_W-1:0] imm;
        alu_op_t          alu_op;
        logic             alu_src;
        logic             mem_to_reg;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic             illegal;
    } dec_lane_t;

    function automatic logic [IMM_W-1:0] sext12(input logic [11:0] value);
        return {{(IMM_W-12){value[11]}}, value};
    endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational single-instruction RV32 decoder; masked-off lanes decode to all zeros.
module decode_lane
    import decode_pkg::*;
(
    input  logic        lane_valid,
    input  logic [31:0] inst,
    output dec_lane_t   dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       bad;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];

    always_comb begin
        dec = '0;
        bad = 1'b0;
        if (lane_valid) begin
            dec.rs1 = inst[19:15];
            dec.rs2 = inst[24:20];
            dec.rd  = inst[11:7];
            case (opcode)
                OP_R: begin
                    dec.reg_write = 1'b1;
                    if (funct7 == F7_BASE && funct3 == F3_ADD_SUB)     dec.alu_op = ALU_ADD;
                    else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) dec.alu_op = ALU_SUB;
                    else if (funct7 == F7_BASE && funct3 == F3_XOR)    dec.alu_op = ALU_XOR;
                    else if (funct7 == F7_ALT && funct3 == F3_SRA)     dec.alu_op = ALU_SRA;
                    else                                               bad = 1'b1;
                end
                OP_I: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.imm       = sext12(inst[31:20]);
                    if (funct3 == F3_ADD_SUB)  dec.alu_op = ALU_ADD;
                    else if (funct3 == F3_AND) dec.alu_op = ALU_AND;
                    else                       bad = 1'b1;
                end
                OP_LOAD: begin
                    dec.alu_src    = 1'b1;
                    dec.reg_write  = 1'b1;
                    dec.mem_read   = 1'b1;
                    dec.mem_to_reg = 1'b1;
                    dec.imm        = sext12(inst[31:20]);
                    bad            = (funct3 != F3_WORD);
                end
                OP_STORE: begin
                    dec.alu_src   = 1'b1;
                    dec.mem_write = 1'b1;
                    dec.imm       = sext12({inst[31:25], inst[11:7]});
                    bad           = (funct3 != F3_WORD);
                end
                default: bad = 1'b1;
            endcase

            // Illegal lanes keep only the raw register fields.
            if (bad) begin
                dec.imm        = '0;
                dec.alu_op     = ALU_ADD;
                dec.alu_src    = 1'b0;
                dec.mem_to_reg = 1'b0;
                dec.reg_write  = 1'b0;
                dec.mem_read   = 1'b0;
                dec.mem_write  = 1'b0;
                dec.illegal    = 1'b1;
            end
            if (dec.rd == 5'd0) dec.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Handshaked multi-lane decode stage between fetch and rename.
// Define DECODE_SKID_EN to add a one-entry skid buffer and break the out_ready -> in_ready path.
module decode_stage
    import decode_pkg::*;
#(
    parameter int LANES = 2,
    parameter int XLEN  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_lane_valid,
    input  logic [LANES*32-1:0]   in_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_lane_valid,
    output logic [LANES*5-1:0]    rs1,
    output logic [LANES*5-1:0]    rs2,
    output logic [LANES*5-1:0]    rd,
    output logic [LANES*XLEN-1:0] imm,
    output logic [LANES*3-1:0]    alu_op,
    output logic [LANES-1:0]      alu_src,
    output logic [LANES-1:0]      mem_to_reg,
    output logic [LANES-1:0]      reg_write,
    output logic [LANES-1:0]      mem_read,
    output logic [LANES-1:0]      mem_write,
    output logic [LANES-1:0]      illegal
);

    dec_lane_t [LANES-1:0] dec_d;
    dec_lane_t [LANES-1:0] out_q;
    logic      [LANES-1:0] out_mask;
    logic                  out_valid_q;
    logic                  accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        decode_lane u_lane (
            .lane_valid (in_lane_valid[i]),
            .inst       (in_inst[32*i +: 32]),
            .dec        (dec_d[i])
        );

        assign rs1[5*i +: 5]       = out_q[i].rs1;
        assign rs2[5*i +: 5]       = out_q[i].rs2;
        assign rd[5*i +: 5]        = out_q[i].rd;
        assign imm[XLEN*i +: XLEN] = XLEN'($signed(out_q[i].imm));
        assign alu_op[3*i +: 3]    = out_q[i].alu_op;
        assign alu_src[i]          = out_q[i].alu_src;
        assign mem_to_reg[i]       = out_q[i].mem_to_reg;
        assign reg_write[i]        = out_q[i].reg_write;
        assign mem_read[i]         = out_q[i].mem_read;
        assign mem_write[i]        = out_q[i].mem_write;
        assign illegal[i]          = out_q[i].illegal;
    end

    assign out_valid      = out_valid_q;
    assign out_lane_valid = out_mask;

`ifdef DECODE_SKID_EN
    dec_lane_t [LANES-1:0] skid_q;
    logic      [LANES-1:0] skid_mask;
    logic                  skid_full;
    logic                  load_slot;

    // Ready depends only on state (and the reset pin), never on out_ready.
    assign in_ready  = rst_n & ~skid_full;
    assign accept    = in_valid & in_ready;
    assign load_slot = ~out_valid_q | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            out_valid_q <= 1'b0;
            skid_full   <= 1'b0;
            if (!rst_n) begin
                out_q     <= '0;
                out_mask  <= '0;
                skid_q    <= '0;
                skid_mask <= '0;
            end
        end else if (load_slot) begin
            // A full skid implies in_ready was low, so nothing new arrives this edge.
            if (skid_full) begin
                out_q       <= skid_q;
                out_mask    <= skid_mask;
                out_valid_q <= 1'b1;
                skid_full   <= 1'b0;
            end else begin
                out_valid_q <= accept;
                if (accept) begin
                    out_q    <= dec_d;
                    out_mask <= in_lane_valid;
                end
            end
        end else if (accept) begin
            skid_q    <= dec_d;
            skid_mask <= in_lane_valid;
            skid_full <= 1'b1;
        end
    end
`else
    assign in_ready = rst_n & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            out_valid_q <= 1'b0;
            if (!rst_n) begin
                out_q    <= '0;
                out_mask <= '0;
            end
        end else if (~out_valid_q | out_ready) begin
            out_valid_q <= accept;
            if (accept) begin
                out_q    <= dec_d;
                out_mask <= in_lane_valid;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage: a queue-based reference of the stage plus
// a mask/match instruction table, pinned by hand-decoded directed cases.
module tb_decode_stage;

    localparam int LANES = 2;
    localparam int XLEN  = 32;
`ifdef DECODE_SKID_EN
    localparam int CAPACITY = 2;
`else
    localparam int CAPACITY = 1;
`endif

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        illegal;
    } lane_exp_t;

    typedef struct packed {
        logic [LANES-1:0]            mask;
        lane_exp_t [LANES-1:0]       lanes;
    } bundle_t;

    // ADD SUB XOR SRA ADDI ANDI LW SW
    localparam logic [31:0] OP_MASK  [8] = '{32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
                                            32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F};
    localparam logic [31:0] OP_MATCH [8] = '{32'h00000033, 32'h40000033, 32'h00004033, 32'h40005033,
                                            32'h00000013, 32'h00007013, 32'h00002003, 32'h00002023};
    localparam logic [2:0]  OP_ALU   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd0, 3'd0};
    // {alu_src, mem_to_reg, reg_write, mem_read, mem_write}
    localparam logic [4:0]  OP_FLAGS [8] = '{5'b00100, 5'b00100, 5'b00100, 5'b00100,
                                            5'b10100, 5'b10100, 5'b11110, 5'b10001};
    // 0: no immediate, 1: I-format, 2: S-format
    localparam int          OP_FMT   [8] = '{0, 0, 0, 0, 1, 1, 1, 2};

    logic                  clk;
    logic                  rst_n;
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES-1:0]      in_lane_valid;
    logic [LANES*32-1:0]   in_inst;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_lane_valid;
    logic [LANES*5-1:0]    rs1;
    logic [LANES*5-1:0]    rs2;
    logic [LANES*5-1:0]    rd;
    logic [LANES*XLEN-1:0] imm;
    logic [LANES*3-1:0]    alu_op;
    logic [LANES-1:0]      alu_src;
    logic [LANES-1:0]      mem_to_reg;
    logic [LANES-1:0]      reg_write;
    logic [LANES-1:0]      mem_read;
    logic [LANES-1:0]      mem_write;
    logic [LANES-1:0]      illegal;

    int checks_total  = 0;
    int checks_passed = 0;

    bundle_t q[$];
    logic    reset_seen = 1'b0;

    decode_stage #(.LANES(LANES), .XLEN(XLEN)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_inst        (in_inst),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .imm            (imm),
        .alu_op         (alu_op),
        .alu_src        (alu_src),
        .mem_to_reg     (mem_to_reg),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference decode: identify the mnemonic first, then derive fields from its row.
    function automatic lane_exp_t model_decode(input logic valid, input logic [31:0] inst);
        lane_exp_t e;
        int op;
        int imm_val;
        e = '0;
        if (!valid) return e;
        e.rs1 = inst[19:15];
        e.rs2 = inst[24:20];
        e.rd  = inst[11:7];
        op = -1;
        for (int k = 0; k < 8; k++)
            if ((inst & OP_MASK[k]) == OP_MATCH[k]) op = k;
        if (op < 0) begin
            e.illegal = 1'b1;
            return e;
        end
        e.alu_op = OP_ALU[op];
        {e.alu_src, e.mem_to_reg, e.reg_write, e.mem_read, e.mem_write} = OP_FLAGS[op];
        imm_val = 0;
        if (OP_FMT[op] == 1) imm_val = int'(inst[31:20]);
        if (OP_FMT[op] == 2) imm_val = int'({inst[31:25], inst[11:7]});
        if (imm_val >= 2048) imm_val = imm_val - 4096;
        e.imm = imm_val;
        if (e.rd == 5'd0) e.reg_write = 1'b0;
        return e;
    endfunction

    function automatic bundle_t model_bundle(input logic [LANES-1:0] mask, input logic [LANES*32-1:0] insts);
        bundle_t b;
        b.mask = mask;
        for (int i = 0; i < LANES; i++) b.lanes[i] = model_decode(mask[i], insts[32*i +: 32]);
        return b;
    endfunction

    function automatic bundle_t pack_dut();
        bundle_t b;
        b.mask = out_lane_valid;
        for (int i = 0; i < LANES; i++) begin
            b.lanes[i].rs1        = rs1[5*i +: 5];
            b.lanes[i].rs2        = rs2[5*i +: 5];
            b.lanes[i].rd         = rd[5*i +: 5];
            b.lanes[i].imm        = imm[XLEN*i +: XLEN];
            b.lanes[i].alu_op     = alu_op[3*i +: 3];
            b.lanes[i].alu_src    = alu_src[i];
            b.lanes[i].mem_to_reg = mem_to_reg[i];
            b.lanes[i].reg_write  = reg_write[i];
            b.lanes[i].mem_read   = mem_read[i];
            b.lanes[i].mem_write  = mem_write[i];
            b.lanes[i].illegal    = illegal[i];
        end
        return b;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [4:0]  d, s1, s2;
        logic [11:0] iv;
        d  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        s1 = 5'($urandom_range(0, 31));
        s2 = 5'($urandom_range(0, 31));
        iv = 12'($urandom);
        case ($urandom_range(0, 11))
            0:  return enc_r(7'h00, s2, s1, 3'd0, d);
            1:  return enc_r(7'h20, s2, s1, 3'd0, d);
            2:  return enc_r(7'h00, s2, s1, 3'd4, d);
            3:  return enc_r(7'h20, s2, s1, 3'd5, d);
            4:  return {iv, s1, 3'd0, d, 7'b0010011};
            5:  return {iv, s1, 3'd7, d, 7'b0010011};
            6:  return {iv, s1, 3'd2, d, 7'b0000011};
            7:  return {iv[11:5], s2, s1, 3'd2, iv[4:0], 7'b0100011};
            8:  return enc_r(7'($urandom), s2, s1, 3'($urandom), d);
            9:  return {iv, s1, 3'($urandom), d, 7'b0010011};
            10: return {iv, s1, 3'($urandom), d, ($urandom_range(0, 1) == 1) ? 7'b0000011 : 7'b0100011};
            default: return $urandom;
        endcase
    endfunction

    // Reference model: the stage behaves as an in-order queue of CAPACITY bundles.
    initial begin
        bundle_t    nb;
        logic       exp_rdy;
        forever begin
            @(negedge clk);
            checkOutput("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) checkOutput("payload", pack_dut(), q[0]);
            if (reset_seen) checkOutput("reset_payload", pack_dut(), '0);
            #4;
            exp_rdy = rst_n && (CAPACITY == 2 ? q.size() < 2 : (q.size() == 0 || out_ready));
            checkOutput("in_ready", in_ready, exp_rdy);
            reset_seen = !rst_n;
            if (!rst_n || flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (in_valid && exp_rdy) begin
                    nb = model_bundle(in_lane_valid, in_inst);
                    q.push_back(nb);
                end
            end
        end
    end

    task automatic waitCheckPoint();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [LANES-1:0] mask, input logic [31:0] i0,
                                 input logic [31:0] i1, input logic ordy, input logic fl, input logic rn);
        #1;
        in_valid      = iv;
        in_lane_valid = mask;
        in_inst       = {i1, i0};
        out_ready     = ordy;
        flush         = fl;
        rst_n         = rn;
    endtask

    logic [31:0] stall_inst [3];
    logic [4:0]  got [$];
    int          idx;
    int          budget;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_lane_valid = '0; in_inst = '0; out_ready = 1'b0;
        repeat (3) waitCheckPoint();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_imm", imm, 0);
        checkOutput("rst_lane_valid", out_lane_valid, 0);
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 1);
        #1 checkOutput("release_in_ready", in_ready, 1);

        waitCheckPoint();
        applyStimulus(1, 2'b01, 32'h002081B3, $urandom, 1, 0, 1);
        waitCheckPoint();
        checkOutput("add_rs1", rs1[4:0], 1);
        checkOutput("add_rs2", rs2[4:0], 2);
        checkOutput("add_rd", rd[4:0], 3);
        checkOutput("add_alu_op", alu_op[2:0], 0);
        checkOutput("add_reg_write", reg_write[0], 1);
        checkOutput("add_imm", imm[31:0], 0);
        checkOutput("add_illegal", illegal[0], 0);
        checkOutput("add_mask", out_lane_valid, 2'b01);
        checkOutput("inv_lane_rd", rd[9:5], 0);

        applyStimulus(1, 2'b01, 32'hFFF00293, 0, 1, 0, 1);
        waitCheckPoint();
        checkOutput("addi_imm", imm[31:0], 32'hFFFFFFFF);
        checkOutput("addi_alu_src", alu_src[0], 1);
        checkOutput("addi_reg_write", reg_write[0], 1);

        applyStimulus(1, 2'b11, 32'hFE20AE23, 32'h00812203, 1, 0, 1);
        waitCheckPoint();
        checkOutput("sw_imm", imm[31:0], 32'hFFFFFFFC);
        checkOutput("sw_mem_write", mem_write[0], 1);
        checkOutput("sw_reg_write", reg_write[0], 0);
        checkOutput("lw_imm", imm[63:32], 8);
        checkOutput("lw_mem_read", mem_read[1], 1);
        checkOutput("lw_mem_to_reg", mem_to_reg[1], 1);

        applyStimulus(1, 2'b11, 32'h00208033, 32'h00000000, 1, 0, 1);
        waitCheckPoint();
        checkOutput("zero_illegal", illegal[1], 1);
        checkOutput("zero_reg_write", reg_write[1], 0);
        checkOutput("x0_reg_write", reg_write[0], 0);
        checkOutput("x0_illegal", illegal[0], 0);

        // Stall: drain first, then stream three ADDs with rd=1,2,3 while out_ready is low.
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) stall_inst[k] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'(k + 1));
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            waitCheckPoint();
            applyStimulus(idx < 3, 2'b01, (idx < 3) ? stall_inst[idx] : 32'h0, 0, 0, 0, 1);
            #2;
            if (in_valid && in_ready) idx++;
        end
        checkOutput("stall_in_ready", in_ready, 0);
        checkOutput("stall_accepted", idx, CAPACITY);
        waitCheckPoint();
        checkOutput("stall_head_rd", rd[4:0], 1);
        got.delete();
        budget = 0;
        while (got.size() < 3 && budget < 20) begin
            if (budget != 0) waitCheckPoint();
            applyStimulus(idx < 3, 2'b01, (idx < 3) ? stall_inst[idx] : 32'h0, 0, 1, 0, 1);
            #2;
            if (out_valid && out_ready) got.push_back(rd[4:0]);
            if (in_valid && in_ready) idx++;
            budget++;
        end
        checkOutput("release_count", got.size(), 3);
        for (int k = 0; k < 3; k++)
            checkOutput("release_order", (got.size() > k) ? got[k] : 5'd0, k + 1);

        // Flush with a full stage and a pending input.
        for (int c = 0; c < 3; c++) begin
            waitCheckPoint();
            applyStimulus(1, 2'b11, rand_inst(), rand_inst(), 0, 0, 1);
        end
        waitCheckPoint();
        applyStimulus(1, 2'b11, rand_inst(), rand_inst(), 0, 1, 1);
        #2 checkOutput("flush_pre_in_ready", in_ready, 0);
        waitCheckPoint();
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_in_ready", in_ready, 1);

        // Flush drops an input even while in_ready is high.
        applyStimulus(1, 2'b11, rand_inst(), rand_inst(), 1, 1, 1);
        waitCheckPoint();
        checkOutput("flush_drop", out_valid, 0);

        // Reset pulse mid-stall behaves like flush.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 2'b11, rand_inst(), rand_inst(), 0, 0, 1);
            waitCheckPoint();
        end
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0);
        waitCheckPoint();
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1);
        #1;
        checkOutput("rstpulse_out_valid", out_valid, 0);
        checkOutput("rstpulse_in_ready", in_ready, 1);

        for (int c = 0; c < 600; c++) begin
            waitCheckPoint();
            applyStimulus($urandom_range(0, 3) != 0, LANES'($urandom), rand_inst(), rand_inst(),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0, $urandom_range(0, 63) != 0);
        end
        waitCheckPoint();
        applyStimulus(0, 2'b00, 0, 0, 1, 0, 1);
        repeat (4) waitCheckPoint();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, handshaked successor to the single-lane decoder in the out-of-order CPU front end. It sits between fetch and rename. Each transfer accepts a bundle of `LANES` RV32 instructions and produces a registered bundle of decoded control fields. Compared with the single-lane decoder it adds valid/ready back-pressure, per-lane valid masks, flush, sign-extended immediates for every supported format, an illegal-instruction flag and x0-write suppression.

## Interface
Parameters:
- `LANES`, default 2: instructions decoded per cycle (1..4).
- `XLEN`, default 32: immediate/data width. Immediates are sign-extended to `XLEN`.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: reset. **Synchronous, active-low.**
- `flush`, in, 1: discard all held and incoming bundles.
- `in_valid`, in, 1: fetch bundle valid.
- `in_ready`, out, 1: stage can accept a bundle.
- `in_lane_valid`, in, `LANES`: per-lane valid mask.
- `in_inst`, in, `LANES*32`: lane i occupies `[32i+31:32i]`.
- `out_valid`, out, 1: decoded bundle valid.
- `out_ready`, in, 1: rename accepts the bundle.
- `out_lane_valid`, out, `LANES`: forwarded mask.
- `rs1`, `rs2`, `rd`, out, `LANES*5` each: register indices.
- `imm`, out, `LANES*XLEN`: sign-extended immediate.
- `alu_op`, out, `LANES*3`: ADD=000, SUB=001, XOR=010, SRA=011, AND=100.
- `alu_src`, `mem_to_reg`, `reg_write`, `mem_read`, `mem_write`, `illegal`, out, `LANES` each: per-lane control bits.

## Operation
- Supported ops: ADD, SUB, XOR, SRA (R-type 0110011), ADDI, ANDI (0010011), LW (0000011, f3=010), SW (0100011, f3=010).
- Immediates:
  - I-type: `inst[31:20]` sign-extended.
  - S-type: `{inst[31:25],inst[11:7]}` sign-extended.
  - R-type: 0.
- Per-lane control bits:
  - `alu_src` = 1 for I, load and store.
  - `mem_to_reg` and `mem_read` = 1 only for LW.
  - `mem_write` = 1 only for SW.
  - `reg_write` = 1 for R, I and LW, forced 0 when `rd`=0.
- Any other opcode/funct3/funct7 combination on a valid lane:
  - `illegal`=1.
  - All write/mem bits 0, `alu_op`=000, `imm`=0.
  - `rs1`/`rs2`/`rd` still carry the raw fields.
- Invalid lanes (mask bit 0):
  - All control bits and `illegal` are 0.
  - Fields are don't-care but must be deterministic: zeros.
- A bundle with `in_lane_valid`=0 and `in_valid`=1 is accepted and forwarded with an all-zero mask.
- Handshake:
  - Input transfer occurs when `in_valid & in_ready`.
  - Output transfer occurs when `out_valid & out_ready`.
  - `out_*` payload stays stable while `out_valid & !out_ready`.
- Flush has priority over every other event in its cycle:
  - Next cycle, `out_valid`=0 and the skid buffer is empty.
  - An input presented in the flush cycle is dropped, even if `in_ready`=1.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 bundle/cycle while `out_ready`=1.
- While `rst_n`=0 (sampled on edge):
  - `out_valid`=0, `out_lane_valid`=0, all payload outputs 0.
  - Skid buffer empty.
  - `in_ready`=0 while `rst_n` is low; 1 in the first cycle after release.
- Reset asserted mid-stall discards held bundles identically to flush.
- Simultaneous output transfer and input transfer: the new bundle replaces the output register in the same edge, with no bubble.

## Configuration
- `DECODE_SKID_EN` defined:
  - One-entry skid buffer behind the output register.
  - `in_ready` is registered: `in_ready` = !skid_full.
  - An input accepted while the output is stalled goes to the skid buffer.
  - The skid buffer drains into the output register on the next output transfer.
  - No combinational path from `out_ready` to `in_ready`.
- `DECODE_SKID_EN` undefined:
  - No skid buffer.
  - `in_ready` = `!out_valid | out_ready`, a combinational path.
- Architectural results are identical with or without the macro.

## Structure
- Shared package `decode_pkg` holds:
  - Opcode, funct3 and funct7 constants.
  - `alu_op` encoding enum.
  - Packed struct `dec_lane_t` with rs1, rs2, rd, imm, alu_op, the control bits and illegal.
- Sub-module `decode_lane`: purely combinational single-instruction decoder, instantiated `LANES` times via generate.
- `decode_stage` owns the registers: output register, optional skid buffer, handshake logic and flush.

## Test plan
- ADD x3,x1,x2 (0x002081B3) in lane 0, mask 01, `out_ready`=1 → next cycle:
  - rs1=1, rs2=2, rd=3, alu_op=000, reg_write=1, imm=0, illegal=0.
- ADDI x5,x0,-1 (0xFFF00293) → imm=0xFFFFFFFF, alu_src=1, reg_write=1.
- SW x2,-4(x1) (0xFE20AE23) plus LW x4,8(x2) (0x00812203) in one bundle:
  - Lane 0: imm=0xFFFFFFFC, mem_write=1, reg_write=0.
  - Lane 1: imm=8, mem_read=1, mem_to_reg=1.
- Hold `out_ready`=0 for 3 cycles while streaming 3 bundles:
  - With `DECODE_SKID_EN`: bundle 1 held stable, bundle 2 in skid, `in_ready`=0.
  - On release: bundles emerge in order 1,2,3, none lost or duplicated.
- 0x00000000 in lane 1 and ADD x0,x1,x2 (0x00208033) in lane 0:
  - Lane 1: illegal=1.
  - Lane 0: reg_write=0.
- Assert `flush` during a stall with the skid buffer full → next cycle `out_valid`=0, `in_ready`=1; a pulse of `rst_n`=0 gives the same result.
